// File: rtl/seq_divider6.sv
// seq_divider6: sequential unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero returns all-ones quotient with a flag.
// Optional macro SEQ_DIVIDER6_EARLY_EXIT_EN: finish immediately when dividend < divisor.
module seq_divider6 #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   p;      // partial remainder, one guard bit
  logic [WIDTH-1:0] d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] v;      // latched divisor
  logic [CW-1:0]    count;

  logic [WIDTH:0]   p_shift_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   p_next_c;
  logic [WIDTH-1:0] d_next_c;

  // One restoring step: shift in next dividend bit, trial-subtract, keep or restore
  always_comb begin
    p_shift_c = {p[WIDTH-1:0], d[WIDTH-1]};
    trial_c   = p_shift_c - {1'b0, v};
    p_next_c  = trial_c[WIDTH] ? p_shift_c : trial_c;
    d_next_c  = {d[WIDTH-2:0], ~trial_c[WIDTH]};
  end

  // Control FSM, datapath registers and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      d           <= '0;
      v           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
`ifdef SEQ_DIVIDER6_EARLY_EXIT_EN
            else if (dividend < divisor) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b0;
            end
`endif
            else begin
              state       <= RUN;
              busy        <= 1'b1;
              done        <= 1'b0;
              d           <= dividend;
              v           <= divisor;
              p           <= '0;
              count       <= '0;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        RUN: begin
          p     <= p_next_c;
          d     <= d_next_c;
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= d_next_c;
            remainder <= p_next_c[WIDTH-1:0];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
